// File: rtl/even_parity_pkg.sv
// rtl/even_parity_pkg.sv - shared FSM state type and default frame width for the even-parity serial transmitter
package even_parity_pkg;

    localparam int DEFAULT_DATA_WIDTH = 3;
    localparam int DEFAULT_CNT_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/even_parity_serial_tx_if.sv
// rtl/even_parity_serial_tx_if.sv - upstream word handshake, serial frame stream and parity-word side outputs
interface even_parity_serial_tx_if
    import even_parity_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  tx_bit;
    logic                  tx_valid;
    logic                  tx_last;
    logic [DATA_WIDTH:0]   par_word;
    logic                  par_word_valid;
    logic [CNT_WIDTH-1:0]  frame_count;

    modport master (
        output in_data, in_valid,
        input  in_ready, tx_bit, tx_valid, tx_last, par_word, par_word_valid, frame_count
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, tx_bit, tx_valid, tx_last, par_word, par_word_valid, frame_count
    );
endinterface

// File: rtl/even_parity_gen.sv
// rtl/even_parity_gen.sv - combinational even-parity bit: XOR reduction of the data word
module even_parity_gen #(
    parameter int DATA_WIDTH = 3
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  parity
);
    assign parity = ^data;
endmodule

// File: rtl/even_parity_serial_tx.sv
// rtl/even_parity_serial_tx.sv - frames a word as MSB-first data bits plus an even parity bit on a serial stream
module even_parity_serial_tx
    import even_parity_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    even_parity_serial_tx_if.slave  bus
);
    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  parity_reg;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [DATA_WIDTH:0]   par_word_reg;
    logic                  par_word_valid_reg;
    logic [CNT_WIDTH-1:0]  frame_count_reg;
    logic                  parity_in;
    logic                  ready;
    logic                  bit_out;
    logic                  valid_out;
    logic                  last_out;
    logic                  accept;
    logic                  last_data_bit;

    even_parity_gen #(.DATA_WIDTH(DATA_WIDTH)) u_parity_gen (
        .data   (bus.in_data),
        .parity (parity_in)
    );

    assign accept        = bus.in_valid && ready;
    assign last_data_bit = (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (last_data_bit) state_next = PARITY;
            PARITY:  state_next = accept ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Accepting in PARITY keeps the stream gapless between frames.
    always_comb begin
        ready     = 1'b1;
        bit_out   = 1'b0;
        valid_out = 1'b0;
        last_out  = 1'b0;
        case (state)
            SHIFT: begin
                ready     = 1'b0;
                bit_out   = shift_reg[DATA_WIDTH-1];
                valid_out = 1'b1;
            end
            PARITY: begin
                bit_out   = parity_reg;
                valid_out = 1'b1;
                last_out  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg          <= '0;
            parity_reg         <= 1'b0;
            bit_cnt            <= '0;
            par_word_reg       <= '0;
            par_word_valid_reg <= 1'b0;
            frame_count_reg    <= '0;
        end else begin
            par_word_valid_reg <= accept;
            if (accept) begin
                shift_reg    <= bus.in_data;
                parity_reg   <= parity_in;
                bit_cnt      <= '0;
                par_word_reg <= {bus.in_data, parity_in};
            end else if (state == SHIFT) begin
                shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
            end
            if (state == PARITY) begin
                frame_count_reg <= frame_count_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.in_ready       = ready;
    assign bus.tx_bit         = bit_out;
    assign bus.tx_valid       = valid_out;
    assign bus.tx_last        = last_out;
    assign bus.par_word       = par_word_reg;
    assign bus.par_word_valid = par_word_valid_reg;
    assign bus.frame_count    = frame_count_reg;
endmodule

// File: tb/tb_even_parity_serial_tx.sv
// tb/tb_even_parity_serial_tx.sv - scoreboard bench for even_parity_serial_tx with directed 3-bit vectors
module tb_even_parity_serial_tx;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    logic [1:0] bit_q[$];
    logic [3:0] pw_q[$];
    // bit i is the hand-computed even parity of the 3-bit value i
    logic [7:0] par_tab;

    even_parity_serial_tx_if #(.DATA_WIDTH(3), .CNT_WIDTH(8)) bus ();

    even_parity_serial_tx #(.DATA_WIDTH(3), .CNT_WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_expected(input logic [2:0] d);
        logic p;
        p = par_tab[d];
        bit_q.push_back({d[2], 1'b0});
        bit_q.push_back({d[1], 1'b0});
        bit_q.push_back({d[0], 1'b0});
        bit_q.push_back({p, 1'b1});
        pw_q.push_back({d, p});
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.tx_valid) begin
                if (bit_q.size() == 0) begin
                    check("unexpected_tx_bit", 32'd1, 32'd0);
                end else begin
                    logic [1:0] e;
                    e = bit_q.pop_front();
                    check("tx_bit", {31'd0, bus.tx_bit}, {31'd0, e[1]});
                    check("tx_last", {31'd0, bus.tx_last}, {31'd0, e[0]});
                end
            end else begin
                check("idle_outputs", {30'd0, bus.tx_bit, bus.tx_last}, 32'd0);
            end
            if (bus.par_word_valid) begin
                if (pw_q.size() == 0) begin
                    check("unexpected_par_word", 32'd1, 32'd0);
                end else begin
                    logic [3:0] w;
                    w = pw_q.pop_front();
                    check("par_word", {28'd0, bus.par_word}, {28'd0, w});
                    check("checker_error", {31'd0, ^bus.par_word}, 32'd0);
                end
            end
        end
    end

    task automatic send(input logic [2:0] d);
        logic acc;
        int   n;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clock);
            acc = bus.in_ready;
            @(posedge clock);
            n++;
        end
        #1;
        check("accept_timeout", {31'd0, acc}, 32'd1);
        if (acc) push_expected(d);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((bit_q.size() != 0 || pw_q.size() != 0) && n < 100) begin
            @(posedge clock);
            n++;
        end
        check("drain_timeout", {31'd0, (n >= 100)}, 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        bit_q.delete();
        pw_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int run;
        int low;
        logic acc;
        checks       = 0;
        errors       = 0;
        par_tab      = 8'b1001_0110;
        reset        = 1'b1;
        bus.in_data  = 3'd0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset_outputs", {27'd0, bus.tx_bit, bus.tx_valid, bus.tx_last, bus.par_word_valid, 1'b0}, 32'd0);
        check("reset_par_word", {28'd0, bus.par_word}, 32'd0);
        check("reset_frame_count", {24'd0, bus.frame_count}, 32'd0);

        send(3'b101);
        drain();
        check("frame_count_after_101", {24'd0, bus.frame_count}, 32'd1);
        check("par_word_101_held", {28'd0, bus.par_word}, 32'h0000000a);

        send(3'b100);
        drain();
        check("par_word_100_held", {28'd0, bus.par_word}, 32'h00000009);
        check("frame_count_after_100", {24'd0, bus.frame_count}, 32'd2);

        // back-to-back: 111 accepted from IDLE, 001 accepted in the PARITY cycle
        bus.in_data  = 3'b111;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        push_expected(3'b111);
        bus.in_data = 3'b001;
        run = 0;
        low = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (bus.tx_valid) run++;
            if (!bus.in_ready) low++;
            if (k == 3) begin
                acc = bus.in_ready;
                @(posedge clock);
                #1;
                check("accept_in_parity", {31'd0, acc}, 32'd1);
                if (acc) push_expected(3'b001);
                bus.in_valid = 1'b0;
            end
        end
        check("contiguous_valid", run, 32'd8);
        check("in_ready_low_cycles", low, 32'd6);
        drain();
        check("frame_count_after_b2b", {24'd0, bus.frame_count}, 32'd4);

        // reset during the second SHIFT cycle
        send(3'b101);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        bit_q.delete();
        pw_q.delete();
        check("async_reset_outputs", {28'd0, bus.tx_bit, bus.tx_valid, bus.tx_last, bus.par_word_valid}, 32'd0);
        check("async_reset_par_word", {28'd0, bus.par_word}, 32'd0);
        check("async_reset_frame_count", {24'd0, bus.frame_count}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("abandoned_not_counted", {24'd0, bus.frame_count}, 32'd0);
        send(3'b110);
        drain();
        check("frame_count_after_reset", {24'd0, bus.frame_count}, 32'd1);

        // 256 frames, sweeping all 3-bit words, to wrap the 8-bit counter
        do_reset();
        for (int i = 0; i < 255; i++) begin
            send(3'(i));
        end
        drain();
        check("frame_count_255", {24'd0, bus.frame_count}, 32'd255);
        send(3'd7);
        drain();
        check("frame_count_wrap", {24'd0, bus.frame_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/even_parity_serial_tx.md
EVEN_PARITY_SERIAL_TX -- requirements
Module: even_parity_serial_tx

Interface
REQ-001 Parameter: DATA_WIDTH, default 3, number of data bits per frame (legal range 2..16).
REQ-002 Parameter: CNT_WIDTH, default 8, width of the sent-frame counter.
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in_data  input  DATA_WIDTH  data word to frame; MSB sent first.
REQ-006 Port: in_valid  input  1  in_data is valid this cycle.
REQ-007 Port: in_ready  output  1  block can accept a word this cycle.
REQ-008 Port: tx_bit  output  1  serial frame bit (data bits, then parity bit).
REQ-009 Port: tx_valid  output  1  tx_bit carries a frame bit this cycle.
REQ-010 Port: tx_last  output  1  current tx_bit is the parity bit.
REQ-011 Port: par_word  output  DATA_WIDTH+1  registered {in_data, parity}, parity in bit 0; this is the word presented to the downstream 4-bit even-parity checker (x,y,z,P order when DATA_WIDTH=3).
REQ-012 Port: par_word_valid  output  1  one-cycle pulse marking a new par_word.
REQ-013 Port: frame_count  output  CNT_WIDTH  number of frames fully transmitted, modulo 2^CNT_WIDTH.

Function
REQ-014 Parity SHALL be even: parity = XOR of all in_data bits, so XOR of par_word is always 0.
REQ-015 FSM SHALL have exactly three states: IDLE, SHIFT, PARITY.
REQ-016 Acceptance SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is captured into a shift register and parity register on that edge.
REQ-017 in_ready SHALL be 1 in IDLE and in PARITY, and 0 in SHIFT.
REQ-018 IDLE -> SHIFT on acceptance; otherwise stays IDLE.
REQ-019 SHIFT SHALL last exactly DATA_WIDTH cycles; tx_bit = captured data bit DATA_WIDTH-1 down to 0, one per cycle; tx_valid=1, tx_last=0.
REQ-020 SHIFT -> PARITY after the DATA_WIDTH-th data bit.
REQ-021 PARITY SHALL last one cycle: tx_bit = parity, tx_valid=1, tx_last=1.
REQ-022 PARITY -> SHIFT if acceptance occurs in that cycle (back-to-back frames, no gap), else PARITY -> IDLE.
REQ-023 Latency: first data bit SHALL appear on tx_bit in the cycle immediately after the accepting edge; a frame occupies exactly DATA_WIDTH+1 consecutive tx_valid cycles.
REQ-024 par_word and par_word_valid SHALL update in the cycle after the accepting edge (same cycle as the first data bit); par_word holds its value until the next acceptance.
REQ-025 frame_count SHALL increment by 1 on the edge that leaves PARITY and wrap from 2^CNT_WIDTH-1 to 0.
REQ-026 In IDLE tx_bit, tx_valid, tx_last and par_word_valid SHALL be 0.
REQ-027 in_data changes while in_ready=0 SHALL have no effect on the frame in progress.

Reset
REQ-028 Asserting reset SHALL immediately force state IDLE, in_ready=1 (once deasserted), tx_bit=0, tx_valid=0, tx_last=0, par_word=0, par_word_valid=0, frame_count=0, independent of clock.
REQ-029 Reset mid-frame SHALL abandon the frame; it is not counted and no further bits of it are emitted.
REQ-030 First acceptance SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-031 Shared package even_parity_pkg SHALL hold the FSM state type (IDLE, SHIFT, PARITY) and the default DATA_WIDTH constant.
REQ-032 Parity computation SHALL be a separate combinational sub-module even_parity_gen (DATA_WIDTH-bit XOR reduction), instantiated once.

Verification
REQ-033 Reset, send in_data=3'b101 -> tx_bit 1,0,1,0 on four consecutive tx_valid cycles, tx_last on 4th, par_word=4'b1010, frame_count 0->1.
REQ-034 Send 3'b100 -> tx_bit 1,0,0,1, par_word=4'b1001; feed par_word to the 4-bit checker -> checker error output 0.
REQ-035 Hold in_valid=1 with 3'b111 then 3'b001 -> accepted in PARITY cycle, 8 contiguous tx_valid cycles 1,1,1,1,0,0,1,1, in_ready low for 3 cycles per frame.
REQ-036 Assert reset during 2nd SHIFT cycle of a frame -> all outputs 0 asynchronously, frame_count stays 0, next frame transmitted cleanly.
REQ-037 Send 256 frames with CNT_WIDTH=8 -> frame_count wraps 255->0; exhaustive sweep 0..7 -> XOR(par_word)=0 for every word.
